// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the two master ports (M0 = RISC-V core,
// M1 = camera/detection DMA) and the single-port Memory side.
//   M0_* / M1_*  : request/lock/write-enable/address/write-data in,
//                  read-data/ack/err out (from the arbiter's view)
//   Mem_*        : address/write-enable/write-data out, read-data in
// Modports: slave = arbiter side, master = masters plus memory side.
interface mem_arbiter_if;
  logic        M0_Req;
  logic        M0_Lock;
  logic        M0_Write_En;
  logic [31:0] M0_Addr;
  logic [31:0] M0_Write_Data;
  logic [31:0] M0_Read_Data;
  logic        M0_Ack;
  logic        M0_Err;

  logic        M1_Req;
  logic        M1_Lock;
  logic        M1_Write_En;
  logic [31:0] M1_Addr;
  logic [31:0] M1_Write_Data;
  logic [31:0] M1_Read_Data;
  logic        M1_Ack;
  logic        M1_Err;

  logic [31:0] Mem_Addr;
  logic        Mem_Write_En;
  logic [31:0] Mem_Write_Data;
  logic [31:0] Mem_Read_Data;

  modport slave (
    input  M0_Req, M0_Lock, M0_Write_En, M0_Addr, M0_Write_Data,
    input  M1_Req, M1_Lock, M1_Write_En, M1_Addr, M1_Write_Data,
    input  Mem_Read_Data,
    output M0_Read_Data, M0_Ack, M0_Err,
    output M1_Read_Data, M1_Ack, M1_Err,
    output Mem_Addr, Mem_Write_En, Mem_Write_Data
  );

  modport master (
    output M0_Req, M0_Lock, M0_Write_En, M0_Addr, M0_Write_Data,
    output M1_Req, M1_Lock, M1_Write_En, M1_Addr, M1_Write_Data,
    output Mem_Read_Data,
    input  M0_Read_Data, M0_Ack, M0_Err,
    input  M1_Read_Data, M1_Ack, M1_Err,
    input  Mem_Addr, Mem_Write_En, Mem_Write_Data
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port Memory between
// two masters, with locked bursts capped at MAX_BURST accesses while the
// other master waits, and misaligned / out-of-range access flagging.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_arbiter_if.slave (both masters + Memory side)
//   Busy       : FSM not in IDLE
//   Owner      : current owner, or last owner while idle
//
// state | meaning
// IDLE  | no owner, no memory access, arbitrates pending requests
// OWN0  | M0 owns the memory; one access per cycle while M0_Req
// OWN1  | M1 owns the memory; one access per cycle while M1_Req
module mem_arbiter #(
  parameter int MEM_WORDS = 64,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus,
  output logic          Busy,
  output logic          Owner
);

  localparam int BW = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_next;
  logic          last_owner, last_owner_next;
  logic [BW-1:0] burst_cnt, burst_cnt_next;

  logic          own1;
  logic          sel_req, sel_lock, sel_we, other_req;
  logic [31:0]   sel_addr, sel_wdata;
  logic          addr_err, access, good, stay;

  assign own1      = (state == OWN1);
  assign sel_req   = own1 ? bus.M1_Req        : bus.M0_Req;
  assign sel_lock  = own1 ? bus.M1_Lock       : bus.M0_Lock;
  assign sel_we    = own1 ? bus.M1_Write_En   : bus.M0_Write_En;
  assign sel_addr  = own1 ? bus.M1_Addr       : bus.M0_Addr;
  assign sel_wdata = own1 ? bus.M1_Write_Data : bus.M0_Write_Data;
  assign other_req = own1 ? bus.M0_Req        : bus.M1_Req;

  assign addr_err = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= 30'(MEM_WORDS));
  assign access   = (state != IDLE) && sel_req;
  assign good     = access && !addr_err;
  // burst_cnt counts contested accesses already taken minus one, so the
  // owner yields after MAX_BURST back-to-back accesses under contention
  assign stay     = sel_req && sel_lock &&
                    (!other_req || (burst_cnt < BW'(MAX_BURST - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      burst_cnt  <= '0;
    end else begin
      state      <= state_next;
      last_owner <= last_owner_next;
      burst_cnt  <= burst_cnt_next;
    end
  end

  always_comb begin
    state_next      = state;
    last_owner_next = last_owner;
    burst_cnt_next  = burst_cnt;
    case (state)
      IDLE: begin
        burst_cnt_next = '0;
        if (bus.M0_Req && bus.M1_Req) state_next = last_owner ? OWN0 : OWN1;
        else if (bus.M0_Req)          state_next = OWN0;
        else if (bus.M1_Req)          state_next = OWN1;
      end
      OWN0, OWN1: begin
        if (stay) begin
          burst_cnt_next = other_req ? burst_cnt + 1'b1 : '0;
        end else begin
          last_owner_next = own1;
          burst_cnt_next  = '0;
          if (other_req) state_next = own1 ? OWN0 : OWN1;
          else           state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.Mem_Addr       = good ? sel_addr : 32'd0;
    bus.Mem_Write_En   = good && sel_we;
    bus.Mem_Write_Data = good ? sel_wdata : 32'd0;

    bus.M0_Ack       = access && !own1;
    bus.M0_Err       = access && !own1 && addr_err;
    bus.M0_Read_Data = (good && !own1) ? bus.Mem_Read_Data : 32'd0;
    bus.M1_Ack       = access && own1;
    bus.M1_Err       = access && own1 && addr_err;
    bus.M1_Read_Data = (good && own1) ? bus.Mem_Read_Data : 32'd0;
  end

  assign Busy  = (state != IDLE);
  assign Owner = (state == OWN0) ? 1'b0 : (state == OWN1) ? 1'b1 : last_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized + directed bench for mem_arbiter. The bench
// plays both masters and the 64-word Memory, and predicts every output from
// a transaction-level model (who holds the grant, who owned last, how many
// contested accesses the owner has taken).
module tb_mem_arbiter;
  localparam int MEM_WORDS = 64;
  localparam int MAX_BURST = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic Busy;
  logic Owner;

  mem_arbiter_if bus ();

  mem_arbiter #(.MEM_WORDS(MEM_WORDS), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .Busy(Busy), .Owner(Owner)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  // Memory: combinational read, synchronous write; preloaded on first edge
  logic [31:0] mem [MEM_WORDS];
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= pat(i);
      mem_ready <= 1'b1;
    end else if (bus.Mem_Write_En) begin
      mem[bus.Mem_Addr[7:2]] <= bus.Mem_Write_Data;
    end
  end
  assign bus.Mem_Read_Data = mem[bus.Mem_Addr[7:2]];

  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // stimulus per master
  logic        req [2];
  logic        lock [2];
  logic        we [2];
  logic [31:0] addr [2];
  logic [31:0] wd [2];

  // reference model
  int          cur;        // -1 = nobody holds the grant
  int          last;
  int          contested;  // contested accesses taken in the current tenure
  logic [31:0] ref_mem [MEM_WORDS];

  // expected and sampled outputs
  logic        e_ack [2], e_err [2], s_ack [2], s_err [2];
  logic [31:0] e_rd [2], s_rd [2];
  logic        e_we, s_we, e_wd_chk, s_busy, s_owner;
  logic [31:0] e_addr, e_wd, s_addr, s_wd;

  function automatic logic is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(MEM_WORDS));
  endfunction

  task automatic model_reset();
    cur = -1;
    last = 1;
    contested = 0;
  endtask

  task automatic expect_outputs();
    for (int m = 0; m < 2; m++) begin
      e_ack[m] = 1'b0; e_err[m] = 1'b0; e_rd[m] = 32'd0;
    end
    e_we = 1'b0; e_addr = 32'd0; e_wd = 32'd0; e_wd_chk = 1'b1;
    if (rst_n && cur >= 0 && req[cur]) begin
      e_ack[cur] = 1'b1;
      if (is_bad(addr[cur])) begin
        e_err[cur] = 1'b1;
        e_wd_chk = 1'b0;
      end else begin
        e_rd[cur] = ref_mem[addr[cur][7:2]];
        e_we = we[cur];
        e_addr = addr[cur];
        e_wd = wd[cur];
      end
    end
  endtask

  task automatic model_edge();
    int o;
    int n;
    logic other;
    if (!rst_n) return;
    if (cur >= 0 && req[cur] && !is_bad(addr[cur]) && we[cur])
      ref_mem[addr[cur][7:2]] = wd[cur];
    if (cur < 0) begin
      if (req[0] && req[1]) cur = 1 - last;
      else if (req[0])      cur = 0;
      else if (req[1])      cur = 1;
      contested = 0;
    end else begin
      o = 1 - cur;
      other = req[o];
      n = other ? contested + 1 : 0;
      if (req[cur] && lock[cur] && (!other || n < MAX_BURST)) begin
        contested = n;
      end else begin
        last = cur;
        cur = other ? o : -1;
        contested = 0;
      end
    end
  endtask

  task automatic apply();
    bus.M0_Req = req[0]; bus.M0_Lock = lock[0]; bus.M0_Write_En = we[0];
    bus.M0_Addr = addr[0]; bus.M0_Write_Data = wd[0];
    bus.M1_Req = req[1]; bus.M1_Lock = lock[1]; bus.M1_Write_En = we[1];
    bus.M1_Addr = addr[1]; bus.M1_Write_Data = wd[1];
  endtask

  // one clock cycle: drive, sample mid-cycle against the model, clock edge
  task automatic cycle();
    apply();
    #3;
    expect_outputs();
    s_ack[0] = bus.M0_Ack; s_err[0] = bus.M0_Err; s_rd[0] = bus.M0_Read_Data;
    s_ack[1] = bus.M1_Ack; s_err[1] = bus.M1_Err; s_rd[1] = bus.M1_Read_Data;
    s_we = bus.Mem_Write_En; s_addr = bus.Mem_Addr; s_wd = bus.Mem_Write_Data;
    s_busy = Busy; s_owner = Owner;
    chk("ack0", 32'(s_ack[0]), 32'(e_ack[0]));
    chk("ack1", 32'(s_ack[1]), 32'(e_ack[1]));
    chk("err0", 32'(s_err[0]), 32'(e_err[0]));
    chk("err1", 32'(s_err[1]), 32'(e_err[1]));
    chk("rd0", s_rd[0], e_rd[0]);
    chk("rd1", s_rd[1], e_rd[1]);
    chk("mem_we", 32'(s_we), 32'(e_we));
    chk("mem_addr", s_addr, e_addr);
    if (e_wd_chk) chk("mem_wd", s_wd, e_wd);
    chk("busy", 32'(s_busy), (rst_n && cur >= 0) ? 32'd1 : 32'd0);
    chk("owner", 32'(s_owner), 32'((rst_n && cur >= 0) ? cur : last));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; lock[m] = 1'b0; we[m] = 1'b0; addr[m] = 32'd0; wd[m] = 32'd0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;
  endtask

  task automatic new_txn(input int m);
    int idx;
    idx = $urandom_range(0, 69);
    req[m] = 1'b1;
    we[m] = 1'($urandom_range(0, 1));
    lock[m] = 1'($urandom_range(0, 1));
    addr[m] = 32'(idx * 4) + (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
    wd[m] = $urandom;
  endtask

  initial begin
    int n0, run, diff;
    logic got1;
    logic [31:0] old;

    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = pat(i);
    idle_inputs();
    model_reset();
    apply();
    @(posedge clk);
    #1;
    do_reset();

    // reset, write then read back
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; wd[0] = 32'hDEADBEEF;
    cycle();
    chk("t1_no_ack_in_idle", 32'(s_ack[0]), 32'd0);
    cycle();
    chk("t1_wr_ack", 32'(s_ack[0]), 32'd1);
    req[0] = 1'b0;
    cycle();
    req[0] = 1'b1; we[0] = 1'b0;
    cycle();
    cycle();
    chk("t1_rd_ack", 32'(s_ack[0]), 32'd1);
    chk("t1_rd_data", s_rd[0], 32'hDEADBEEF);
    req[0] = 1'b0;
    cycle();
    chk("t1_busy_after", 32'(s_busy), 32'd0);

    // ties
    do_reset();
    req[0] = 1'b1; addr[0] = 32'h04; req[1] = 1'b1; addr[1] = 32'h08;
    cycle();
    cycle();
    chk("t2_tie_m0_first", 32'(s_ack[0]), 32'd1);
    chk("t2_tie_m1_wait", 32'(s_ack[1]), 32'd0);
    req[0] = 1'b0;
    cycle();
    chk("t2_m1_no_bubble", 32'(s_ack[1]), 32'd1);
    req[1] = 1'b0;
    cycle();
    cycle();
    req[0] = 1'b1; req[1] = 1'b1;
    cycle();
    cycle();
    chk("t2_tie2_m0", 32'(s_ack[0]), 32'd1);
    chk("t2_tie2_m1_wait", 32'(s_ack[1]), 32'd0);
    req[0] = 1'b0;
    cycle();
    req[1] = 1'b0;
    cycle();

    // starvation bound, then uncontended lock
    do_reset();
    req[0] = 1'b1; lock[0] = 1'b1; addr[0] = 32'h10;
    req[1] = 1'b1; addr[1] = 32'h14;
    n0 = 0; got1 = 1'b0;
    for (int i = 0; i < 40 && !got1; i++) begin
      cycle();
      if (s_ack[1]) got1 = 1'b1;
      else if (s_ack[0]) n0++;
    end
    chk("t3_m1_granted", 32'(got1), 32'd1);
    chk("t3_m0_burst_len", 32'(n0), 32'(MAX_BURST));
    req[1] = 1'b0;
    run = 0;
    repeat (25) begin
      cycle();
      if (s_ack[0]) run++;
    end
    chk("t3_uncontended_run", 32'(run), 32'd25);
    req[0] = 1'b0; lock[0] = 1'b0;
    cycle();
    cycle();

    // error accesses
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h102; wd[1] = 32'hCAFEF00D;
    cycle();
    cycle();
    chk("t4_mis_ack", 32'(s_ack[1]), 32'd1);
    chk("t4_mis_err", 32'(s_err[1]), 32'd1);
    chk("t4_mis_we", 32'(s_we), 32'd0);
    addr[1] = 32'h100;
    cycle();
    cycle();
    chk("t4_oor_ack", 32'(s_ack[1]), 32'd1);
    chk("t4_oor_err", 32'(s_err[1]), 32'd1);
    chk("t4_oor_we", 32'(s_we), 32'd0);
    req[1] = 1'b0;
    cycle();
    diff = 0;
    for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) diff++;
    chk("t4_mem_unchanged", 32'(diff), 32'd0);

    // reset in the middle of a write
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20; wd[1] = 32'h12345678;
    old = ref_mem[8];
    cycle();
    apply();
    #3;
    chk("t5_we_before", 32'(bus.Mem_Write_En), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_we_drop", 32'(bus.Mem_Write_En), 32'd0);
    chk("t5_ack_drop", 32'(bus.M1_Ack), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("t5_word8_kept", mem[8], old);
    req[1] = 1'b0;
    apply();
    rst_n = 1'b1;
    cycle();
    chk("t5_idle_after", 32'(s_busy), 32'd0);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int m = 0; m < 2; m++)
        if (!req[m] && $urandom_range(0, 2) == 0) new_txn(m);
      cycle();
      for (int m = 0; m < 2; m++) begin
        if (e_ack[m]) begin
          if (lock[m] && $urandom_range(0, 3) != 0) new_txn(m);
          else req[m] = 1'b0;
        end else if (req[m] && $urandom_range(0, 15) == 0) begin
          lock[m] = ~lock[m];
        end
      end
    end
    idle_inputs();
    cycle();
    cycle();
    diff = 0;
    for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) diff++;
    chk("rand_mem_contents", 32'(diff), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares the single-port unified `Memory` (combinational read, synchronous write, 64 words) between the multi-cycle RISC-V core (M0) and the camera/detection DMA engine (M1). It grants one owner at a time with round-robin fairness, supports locked bursts with a starvation bound, and flags misaligned or out-of-range accesses. It sits between both masters and the `Memory` instance; neither master drives `Memory` directly.

## Interface
- `MEM_WORDS`, 64: number of 32-bit words in `Memory`. The valid word index range is 0..MEM_WORDS-1.
- `MAX_BURST`, 8: maximum consecutive accesses by one owner while the other master is requesting. Must be ≥1.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `M0_Req` / `M1_Req`  in  1  access request; held with address/data until `Mx_Ack`.
- `M0_Lock` / `M1_Lock`  in  1  owner has another access immediately after the current one.
- `M0_Write_En` / `M1_Write_En`  in  1  1 = write, 0 = read.
- `M0_Addr` / `M1_Addr`  in  32  byte address.
- `M0_Write_Data` / `M1_Write_Data`  in  32  write data.
- `M0_Read_Data` / `M1_Read_Data`  out  32  read data; valid in the `Ack` cycle; 0 when not owner.
- `M0_Ack` / `M1_Ack`  out  1  one-cycle completion pulse, combinational in the access cycle.
- `M0_Err` / `M1_Err`  out  1  qualifies `Ack`: misaligned or out-of-range access.
- `Mem_Addr`  out  32  to `Memory` `Addr`.
- `Mem_Write_En`  out  1  to `Memory` `Write_En`.
- `Mem_Write_Data`  out  32  to `Memory` `Write_Data`.
- `Mem_Read_Data`  in  32  from `Memory` `Read_Data`.
- `Busy`  out  1  FSM not in IDLE.
- `Owner`  out  1  current or last owner index.

## Operation
- FSM states: IDLE, OWN0, OWN1. Registers: `state`, `Last_Owner`, `Burst_Cnt` (width clog2(MAX_BURST)+1).
- **IDLE.**
  - If only Mx_Req is asserted, go to OWNx.
  - If both requests are asserted, grant the master ≠ `Last_Owner`.
  - If neither is asserted, stay in IDLE.
  - No memory access occurs in IDLE; `Mem_*` outputs are 0.
- **OWNx, access cycle.** If Mx_Req=1:
  - Drive `Mem_Addr`, `Mem_Write_Data`, and `Mem_Write_En` from Mx, and route `Mem_Read_Data` to `Mx_Read_Data`.
  - Pulse `Mx_Ack`.
  - A write commits at the rising edge that ends the cycle.
  - If Mx_Req=0, there is no access and no Ack.
- **Error check.** The access is in error if Mx_Addr[1:0]≠0 or Mx_Addr[31:2] ≥ MEM_WORDS. In that case:
  - `Mx_Ack`=1 and `Mx_Err`=1.
  - `Mem_Write_En`=0 and `Mem_Addr`=0.
  - `Mx_Read_Data`=0.
- **OWNx exit, evaluated at the end of each OWNx cycle.** Let other = My_Req.
  - Stay in OWNx if Mx_Req && Mx_Lock && (!other || Burst_Cnt < MAX_BURST-1). On staying, `Burst_Cnt` becomes other ? Burst_Cnt+1 : 0.
  - Otherwise, if other=1, go to OWNy, set `Last_Owner`=x, and clear `Burst_Cnt`.
  - Otherwise go to IDLE, set `Last_Owner`=x, and clear `Burst_Cnt`.
- **Unlocked masters.** An unlocked master's next access re-arbitrates, so it either passes through IDLE or hands off directly to the other master.
- **Output drive.** A non-owner always sees `Ack`=0, `Err`=0, and `Read_Data`=0.
- **Owner output.** `Owner` = x in OWNx; in IDLE it equals `Last_Owner`.

## Timing
- **Reset values.** `state`=IDLE, `Last_Owner`=1 (so M0 wins the first tie), `Burst_Cnt`=0.
  - All `Ack`, `Err`, `Read_Data`, `Mem_*`, and `Busy` outputs are 0; `Owner`=1.
- **Reset mid-access.** Outputs clear asynchronously; no write commits at the next edge.
- **Latency from IDLE.** Req sampled at edge N gives Ack in cycle N+1.
- **Locked burst.** One access per cycle with no bubbles.
- **Handoff.** OWNx→OWNy has no bubble: the first y access is in the cycle after the last x access.
- **Starvation bound.** With the other master requesting, the owner gets at most MAX_BURST consecutive accesses.
- **Uncontended lock.** A locked owner with no contention holds the grant indefinitely.
- **Simultaneous requests.** A tie in IDLE is resolved purely by `Last_Owner`.
- **Release.** Dropping Req while in OWNx with Lock=1 is treated as a release.
- **Read-after-write.** A read of the same word in the cycle after a write returns the new data.

## Test plan
- **Reset, then single transaction.** Hold rst_n=0, then release. M0 writes 0xDEADBEEF to 0x10 and then reads 0x10.
  - Ack arrives 1 cycle after Req.
  - The read returns 0xDEADBEEF.
  - Busy returns to 0 afterwards.
- **Tie from reset.** M0 and M1 both Req (unlocked) in the same cycle.
  - M0 is served first, M1 next cycle with no bubble.
  - A second tie afterwards grants M0 (Last_Owner=1).
- **Starvation bound.** M0 is locked and issues continuous reads while M1 Req is held, MAX_BURST=8.
  - Exactly 8 M0 Acks occur, then M1 is granted.
  - Without M1 Req, M0 keeps 20+ consecutive Acks.
- **Error access.** M1 writes to 0x102 (misaligned), then to 0x100 (word 64 is out of range).
  - Both return Ack+Err.
  - Mem_Write_En stays 0.
  - Memory contents are unchanged.
- **Reset during write.** Assert rst_n low mid-cycle during an M1 write to 0x20 of 0x12345678.
  - Mem_Write_En drops immediately.
  - Word 8 keeps its old value.
  - The FSM is in IDLE after release.
